mult_bcd_conv: RTL and testbench

//  Sequential signed-binary to BCD converter downstream of the array multiplier.

---
 rtl/mult_bcd_conv.sv | 157 +++++++++++++++
 tb/tb_mult_bcd_conv.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_bcd_conv.sv
// mult_bcd_conv: sequential signed-binary to packed-BCD converter.
// Double dabble, one product bit per clock, DIGITS+1 scratch digits.
// Ports: clk, rst (async, high), start, product[2M-1:0] (signed),
//   busy (SHIFT), done (1-cycle), neg, ovf, bcd[4*DIGITS-1:0].
// Option: MULT_BCD_ZERO_BLANK_EN blanks leading zero digits with 4'hF.
module mult_bcd_conv #(
   parameter int M      = 4,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [2*M-1:0]        product,
   output logic                  busy,
   output logic                  done,
   output logic                  neg,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int W  = 2 * M;
   localparam int SW = 4 * (DIGITS + 1);
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    mag_q, mag_d;
   logic            sign_q, sign_d;
   logic [SW-1:0]   scr_q, scr_d;
   logic            lost_q, lost_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            neg_q, neg_d;
   logic            ovf_q, ovf_d;

   logic [SW-1:0]   scr_adj;
   logic [SW-1:0]   scr_sh;
   logic [W-1:0]    mag_sh;
   logic            lost_sh;
   logic            hi_nz;
   logic [BW-1:0]   res;
   logic            lead;

   // state register and datapath flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         scr_q   <= '0;
         lost_q  <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         scr_q   <= scr_d;
         lost_q  <= lost_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   // one double-dabble step plus the result the step would produce
   always_comb begin
      scr_adj = scr_q;
      for (int i = 0; i <= DIGITS; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) begin
            scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
         end
      end
      scr_sh  = {scr_adj[SW-2:0], mag_q[W-1]};
      mag_sh  = {mag_q[W-2:0], 1'b0};
      // a bit pushed out of the top digit also means overflow
      lost_sh = lost_q | scr_adj[SW-1];
      hi_nz   = (scr_sh[SW-1 -: 4] != 4'd0) | lost_sh;
      res     = scr_sh[BW-1:0];
      lead    = 1'b1;
`ifdef MULT_BCD_ZERO_BLANK_EN
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (res[4*i +: 4] == 4'd0)) begin
            res[4*i +: 4] = 4'hF;
         end else begin
            lead = 1'b0;
         end
      end
`endif
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_SHIFT;
         S_SHIFT: if (cnt_q == CW'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath next values
   always_comb begin
      cnt_d  = cnt_q;
      mag_d  = mag_q;
      sign_d = sign_q;
      scr_d  = scr_q;
      lost_d = lost_q;
      bcd_d  = bcd_q;
      neg_d  = neg_q;
      ovf_d  = ovf_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               // -2^(W-1) negates to itself, read back as unsigned 2^(W-1)
               mag_d  = product[W-1] ? (~product + W'(1)) : product;
               sign_d = product[W-1];
               scr_d  = '0;
               lost_d = 1'b0;
               cnt_d  = CW'(W);
            end
         end
         S_SHIFT: begin
            scr_d  = scr_sh;
            mag_d  = mag_sh;
            lost_d = lost_sh;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               neg_d = sign_q;
               ovf_d = hi_nz;
               bcd_d = hi_nz ? {DIGITS{4'h9}} : res;
            end
         end
         default: ;
      endcase
   end

   // outputs
   always_comb begin
      busy = (state_q == S_SHIFT);
      done = (state_q == S_DONE);
      neg  = neg_q;
      ovf  = ovf_q;
      bcd  = bcd_q;
   end

endmodule

// File: tb/tb_mult_bcd_conv.sv
// Bench for mult_bcd_conv: DIGITS=3 and DIGITS=2 instances,
// directed vectors, scoreboard queues checked by done monitors.
module tb_mult_bcd_conv;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start3, start2;
   logic [7:0]  product3, product2;
   logic        busy3, done3, neg3, ovf3;
   logic        busy2, done2, neg2, ovf2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      logic [13:0] res;
      int          cyc;
   } exp3_t;

   typedef struct {
      logic [9:0] res;
      int         cyc;
   } exp2_t;

   exp3_t q3[$];
   exp2_t q2[$];

   mult_bcd_conv #(.M(4), .DIGITS(3)) u_d3 (
      .clk(clk), .rst(rst), .start(start3), .product(product3),
      .busy(busy3), .done(done3), .neg(neg3), .ovf(ovf3), .bcd(bcd3)
   );

   mult_bcd_conv #(.M(4), .DIGITS(2)) u_d2 (
      .clk(clk), .rst(rst), .start(start2), .product(product2),
      .busy(busy2), .done(done2), .neg(neg2), .ovf(ovf2), .bcd(bcd2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (cycle %0d)", nm, cyc);
   endtask

   // monitors
   always @(negedge clk) begin
      if (done3) begin
         if (q3.size() == 0) begin
            fail_now("d3_unexpected_done");
         end else begin
            exp3_t e;
            e = q3.pop_front();
            chk("d3_result", 32'({neg3, ovf3, bcd3}), 32'(e.res));
            chk("d3_latency", cyc, e.cyc);
         end
      end
   end

   always @(negedge clk) begin
      if (done2) begin
         if (q2.size() == 0) begin
            fail_now("d2_unexpected_done");
         end else begin
            exp2_t e;
            e = q2.pop_front();
            chk("d2_result", 32'({neg2, ovf2, bcd2}), 32'(e.res));
            chk("d2_latency", cyc, e.cyc);
         end
      end
   end

   function automatic logic [11:0] pick3(input logic [11:0] pl,
                                         input logic [11:0] bl);
`ifdef MULT_BCD_ZERO_BLANK_EN
      return bl;
`else
      return pl;
`endif
   endfunction

   function automatic logic [7:0] pick2(input logic [7:0] pl,
                                        input logic [7:0] bl);
`ifdef MULT_BCD_ZERO_BLANK_EN
      return bl;
`else
      return pl;
`endif
   endfunction

   task automatic wait_done3();
      int n = 0;
      while (!done3 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done3) fail_now("d3_done_timeout");
   endtask

   task automatic wait_done2();
      int n = 0;
      while (!done2 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done2) fail_now("d2_done_timeout");
   endtask

   task automatic push3(input logic [11:0] b, input logic n,
                        input logic o, input int dc);
      exp3_t e;
      e.res = {n, o, b};
      e.cyc = dc;
      q3.push_back(e);
   endtask

   task automatic run3(input logic [7:0] p, input logic [11:0] pl,
                       input logic [11:0] bl, input logic n,
                       input logic o);
      @(negedge clk);
      start3   = 1'b1;
      product3 = p;
      @(posedge clk);
      #1;
      push3(pick3(pl, bl), n, o, cyc + W);
      start3   = 1'b0;
      product3 = 8'h5A;
      @(negedge clk);
      chk("d3_busy", 32'(busy3), 32'd1);
      wait_done3();
   endtask

   task automatic run2(input logic [7:0] p, input logic [7:0] pl,
                       input logic [7:0] bl, input logic n,
                       input logic o);
      exp2_t e;
      @(negedge clk);
      start2   = 1'b1;
      product2 = p;
      @(posedge clk);
      #1;
      e.res    = {n, o, pick2(pl, bl)};
      e.cyc    = cyc + W;
      q2.push_back(e);
      start2   = 1'b0;
      product2 = 8'hA5;
      wait_done2();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  hv[3];
      logic [11:0] hp[3];
      logic [11:0] hb[3];
      logic        hn[3];
      int          acc;

      rst      = 1'b1;
      start3   = 1'b0;
      start2   = 1'b0;
      product3 = 8'h00;
      product2 = 8'h00;
      repeat (2) @(negedge clk);
      chk("reset_d3", 32'({busy3, done3, neg3, ovf3, bcd3}), 32'd0);
      chk("reset_d2", 32'({busy2, done2, neg2, ovf2, bcd2}), 32'd0);
      rst = 1'b0;

      run3(8'd56,  12'h056, 12'hF56, 1'b0, 1'b0);
      run3(8'hC0,  12'h064, 12'hF64, 1'b1, 1'b0);
      run3(8'h80,  12'h128, 12'h128, 1'b1, 1'b0);
      run3(8'h00,  12'h000, 12'hFF0, 1'b0, 1'b0);
      run3(8'd7,   12'h007, 12'hFF7, 1'b0, 1'b0);
      run3(8'd127, 12'h127, 12'h127, 1'b0, 1'b0);
      run3(8'hF6,  12'h010, 12'hF10, 1'b1, 1'b0);

      run2(8'd127, 8'h99, 8'h99, 1'b0, 1'b1);
      run2(8'd99,  8'h99, 8'h99, 1'b0, 1'b0);
      run2(8'd5,   8'h05, 8'hF5, 1'b0, 1'b0);
      run2(8'h9C,  8'h99, 8'h99, 1'b1, 1'b1);

      // start held high, product changing every cycle
      hv[0] = 8'd25; hp[0] = 12'h025; hb[0] = 12'hF25; hn[0] = 1'b0;
      hv[1] = 8'h9D; hp[1] = 12'h099; hb[1] = 12'hF99; hn[1] = 1'b1;
      hv[2] = 8'd100; hp[2] = 12'h100; hb[2] = 12'h100; hn[2] = 1'b0;
      @(negedge clk);
      start3   = 1'b1;
      product3 = hv[0];
      @(posedge clk);
      #1;
      acc = cyc;
      push3(pick3(hp[0], hb[0]), hn[0], 1'b0, acc + W);
      for (int k = 1; k < 3; k++) begin
         repeat (W + 1) begin
            @(negedge clk);
            product3 = 8'd77;
         end
         @(negedge clk);
         product3 = hv[k];
         @(posedge clk);
         #1;
         push3(pick3(hp[k], hb[k]), hn[k], 1'b0, acc + k * (W + 2) + W);
      end
      start3 = 1'b0;
      wait_done3();

      // reset in the middle of a conversion
      run3(8'h80, 12'h128, 12'h128, 1'b1, 1'b0);
      @(negedge clk);
      start3   = 1'b1;
      product3 = 8'd42;
      @(posedge clk);
      #1;
      start3 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_reset_d3", 32'({busy3, done3, neg3, ovf3, bcd3}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("no_done_after_abort", 32'(q3.size()), 32'd0);
      run3(8'hFF, 12'h001, 12'hFF1, 1'b1, 1'b0);

      repeat (4) @(negedge clk);
      chk("q3_drained", 32'(q3.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
